mnist_nn_loader: RTL

- Host-side sequencer that sits directly upstream of the mnist_nn top and drives its off-chip ("_oc") load port and its en_compute input.
- Accepts load commands plus a valid/ready 1-bit data stream, and writes the bits into the W or X memory bank at sequential addresses.
- On a run request, hands memory control to the compute module and waits for compute_finish.

---
 rtl/mnist_nn_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mnist_nn_loader.sv
// Host-side load/run sequencer in front of mnist_nn: streams 1-bit data into the W/X banks, then hands the memories to compute.
// Optional MNIST_LOADER_CHECKSUM_EN adds chk_count, a saturating count of 1-bits written since the last accepted command.
`timescale 1ns/1ps
module mnist_nn_loader #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_target,
  input  logic [1:0]            cmd_sel,
  input  logic [W_ADDR_LEN:0]   cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_bit,
  input  logic                  run,
  input  logic                  compute_finish,
  output logic                  load_compute_ctrl,
  output logic                  en_compute,
  output logic                  w_wq_oc,
  output logic                  x_wq_oc,
  output logic [W_ADDR_LEN-1:0] w_addr_oc,
  output logic [X_ADDR_LEN-1:0] x_addr_oc,
  output logic                  wx_write_oc,
  output logic [W_SEL_LEN-1:0]  w_sel_oc,
  output logic [X_SEL_LEN-1:0]  x_sel_oc,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef MNIST_LOADER_CHECKSUM_EN
  ,
  output logic [W_ADDR_LEN:0]   chk_count
`endif
);

  localparam logic [W_ADDR_LEN:0] X_MAX_LEN = (W_ADDR_LEN+1)'(1) << X_ADDR_LEN;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t state_q, state_d;

  logic                  cmd_acc_p0, cmd_rej_p0, run_acc_p0, run_done_p0, bit_acc_p0;
  logic                  tgt_q;
  logic [1:0]            sel_q;
  logic [W_ADDR_LEN:0]   rem_q;
  logic [W_ADDR_LEN-1:0] addr_q;

`ifdef MNIST_LOADER_CHECKSUM_EN
  function automatic logic [W_ADDR_LEN:0] sat_inc(input logic [W_ADDR_LEN:0] v);
    return (&v) ? v : v + (W_ADDR_LEN+1)'(1);
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    cmd_acc_p0  = 1'b0;
    cmd_rej_p0  = 1'b0;
    run_acc_p0  = 1'b0;
    run_done_p0 = 1'b0;
    bit_acc_p0  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A command in the same cycle as run takes priority.
        if (cmd_ready && cmd_valid) begin
          if (cmd_target && (cmd_len > X_MAX_LEN)) begin
            cmd_rej_p0 = 1'b1;
          end else begin
            cmd_acc_p0 = 1'b1;
            if (cmd_len != '0) state_d = S_LOAD;
          end
        end else if (cmd_ready && run) begin
          run_acc_p0 = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          bit_acc_p0 = 1'b1;
          // The all-ones address check stops an oversize W load before the counter wraps.
          if ((rem_q == (W_ADDR_LEN+1)'(1)) || (!tgt_q && (&addr_q))) state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (compute_finish) begin
          run_done_p0 = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // p0 -> p1: control state and registered memory port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= S_IDLE;
      cmd_ready         <= 1'b0;
      in_ready          <= 1'b0;
      busy              <= 1'b0;
      en_compute        <= 1'b0;
      load_compute_ctrl <= 1'b1;
      done              <= 1'b0;
      err               <= 1'b0;
      w_wq_oc           <= 1'b0;
      x_wq_oc           <= 1'b0;
      w_addr_oc         <= '0;
      x_addr_oc         <= '0;
      wx_write_oc       <= 1'b0;
      w_sel_oc          <= '0;
      x_sel_oc          <= '0;
    end else begin
      state_q           <= state_d;
      cmd_ready         <= (state_d == S_IDLE);
      in_ready          <= (state_d == S_LOAD);
      busy              <= (state_d != S_IDLE);
      en_compute        <= (state_d == S_RUN);
      load_compute_ctrl <= (state_d != S_RUN);
      w_wq_oc           <= bit_acc_p0 && !tgt_q;
      x_wq_oc           <= bit_acc_p0 && tgt_q;
      if (cmd_rej_p0)      err <= 1'b1;
      else if (cmd_acc_p0) err <= 1'b0;
      if (run_done_p0)                   done <= 1'b1;
      else if (cmd_acc_p0 || run_acc_p0) done <= 1'b0;
      if (bit_acc_p0) begin
        wx_write_oc <= in_bit;
        if (tgt_q) begin
          x_addr_oc <= addr_q[X_ADDR_LEN-1:0];
          x_sel_oc  <= X_SEL_LEN'(sel_q);
        end else begin
          w_addr_oc <= addr_q;
          w_sel_oc  <= W_SEL_LEN'(sel_q);
        end
      end
    end
  end

  // p0: latched command and address/remaining counters
  always_ff @(posedge clk) begin
    if (cmd_acc_p0) begin
      tgt_q  <= cmd_target;
      sel_q  <= cmd_sel;
      rem_q  <= cmd_len;
      addr_q <= '0;
    end else if (bit_acc_p0) begin
      rem_q  <= rem_q - (W_ADDR_LEN+1)'(1);
      addr_q <= addr_q + W_ADDR_LEN'(1);
    end
  end

`ifdef MNIST_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      chk_count <= '0;
    else if (cmd_acc_p0)           chk_count <= '0;
    else if (bit_acc_p0 && in_bit) chk_count <= sat_inc(chk_count);
  end
`endif

endmodule
